// File: rtl/count_seq_ctrl.sv
// Start/limit sequencer for an up-counter: one-shot or auto-reload runs.
// Define CNT_CTRL_PRESCALE_EN to divide the count step by prescale+1.
module count_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_limit,
  input  logic             start_reload,
  input  logic             stop,
  input  logic             pause,
  input  logic [PRE_W-1:0] prescale,
  input  logic             done_ack,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             rld_q, rld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             accept;
  logic             tick;
  logic             step;

`ifdef CNT_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  // >= keeps a live shrink of prescale from stalling a full wrap
  assign tick = (pre_q >= prescale);

  always_comb begin
    pre_d = pre_q;
    if (accept || (state_q == RUN && stop)) begin
      pre_d = '0;
    end else if (state_q == RUN && !pause) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end
`else
  logic unused_prescale;

  assign unused_prescale = ^prescale;
  assign tick = 1'b1;
`endif

  assign start_ready = (state_q == IDLE);
  assign accept      = start_valid && start_ready;
  assign step        = !pause && tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          lim_d   = start_limit;
          rld_d   = start_reload;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (step) begin
          if (cnt_q != lim_q) begin
            cnt_d = cnt_q + WIDTH'(1);
          end else begin
            tc_d = 1'b1;
            if (rld_q) begin
              cnt_d = '0;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (done_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      rld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef CNT_CTRL_PRESCALE_EN
      pre_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      rld_q   <= rld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
`ifdef CNT_CTRL_PRESCALE_EN
      pre_q   <= pre_d;
`endif
    end
  end

  assign cnt      = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: one-shot, reload, pause, stop,
// ack/start overlap, limit extremes and reset mid-run.
module tb_count_seq_ctrl;

  localparam int W = 4;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] start_limit;
  logic         start_reload;
  logic         stop;
  logic         pause;
  logic [P-1:0] prescale;
  logic         done_ack;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         tc_pulse;

  int n_chk  = 0;
  int n_pass = 0;
  int n_tc;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(W), .PRE_W(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_limit  (start_limit),
    .start_reload (start_reload),
    .stop         (stop),
    .pause        (pause),
    .prescale     (prescale),
    .done_ack     (done_ack),
    .cnt          (cnt),
    .busy         (busy),
    .done         (done),
    .tc_pulse     (tc_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // advance one edge; outputs are stable 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // status word: {ready,busy,done,tc}
  function automatic int st();
    return {start_ready, busy, done, tc_pulse};
  endfunction

  task automatic start(input int lim, input bit rld);
    start_valid  = 1'b1;
    start_limit  = W'(lim);
    start_reload = rld;
    cyc();
    start_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 0; start_limit = 0; start_reload = 0;
    stop = 0; pause = 0; prescale = 0; done_ack = 0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_cnt", cnt, 0);
    check("rst_st", st(), 4'b1000);

    // one-shot limit 5
    start(5, 1'b0);
    check("os_start_cnt", cnt, 0);
    check("os_start_st", st(), 4'b0100);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("os_cnt", cnt, i);
      check("os_st", st(), 4'b0100);
    end
    cyc();
    check("os_term_st", st(), 4'b0011);
    check("os_term_cnt", cnt, 5);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("os_done_st", st(), 4'b0010);
    check("os_done_cnt", cnt, 5);

    // start + ack together in DONE: ack only
    start_valid = 1'b1; start_limit = 3; start_reload = 1'b1; done_ack = 1'b1;
    cyc();
    done_ack = 1'b0;
    check("ack_st", st(), 4'b1000);
    check("ack_cnt", cnt, 5);
    cyc();
    start_valid = 1'b0;
    check("rl_start_st", st(), 4'b0100);
    check("rl_start_cnt", cnt, 0);

    // reload limit 3 for 12 cycles
    n_tc = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (tc_pulse) n_tc++;
      check("rl_cnt", cnt, k % 4);
      check("rl_tc", tc_pulse, int'(k % 4 == 0));
      check("rl_done", done, 0);
    end
    check("rl_ntc", n_tc, 3);

    // stray start/ack during RUN are ignored
    start_valid = 1'b1; start_limit = 9; done_ack = 1'b1;
    cyc();
    cyc();
    start_valid = 1'b0; done_ack = 1'b0;
    check("ign_cnt", cnt, 2);
    check("ign_st", st(), 4'b0100);

    // stop with pause at cnt 2
    stop = 1'b1; pause = 1'b1;
    cyc();
    stop = 1'b0; pause = 1'b0;
    check("stop_cnt", cnt, 0);
    check("stop_st", st(), 4'b1000);

    // limit 9 with 3-cycle pause at cnt 4
    start(9, 1'b0);
    for (int i = 1; i <= 4; i++) cyc();
    check("pz_pre", cnt, 4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pz_hold", cnt, 4);
      check("pz_st", st(), 4'b0100);
    end
    pause = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      cyc();
      check("pz_cnt", cnt, i);
    end
    check("pz_not_done", done, 0);
    cyc();
    check("pz_term_st", st(), 4'b0011);

    // limit 0 reload: tc every cycle
    done_ack = 1'b1;
    cyc();
    done_ack = 1'b0;
    start(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("l0_tc", tc_pulse, 1);
      check("l0_cnt", cnt, 0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // all-ones limit: reaches 15, no wrap
    start(15, 1'b0);
    for (int i = 1; i <= 15; i++) cyc();
    check("max_cnt", cnt, 15);
    check("max_pre_st", st(), 4'b0100);
    cyc();
    check("max_term_st", st(), 4'b0011);
    check("max_term_cnt", cnt, 15);
    done_ack = 1'b1;
    cyc();
    done_ack = 1'b0;

    // reset mid-run
    start(7, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_cnt", cnt, 0);
    check("mrst_st", st(), 4'b1000);
    cyc();
    check("mrst_idle", st(), 4'b1000);

`ifdef CNT_CTRL_PRESCALE_EN
    prescale = 2;
    start(2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("ps_cnt", cnt, i / 3);
      check("ps_st", st(), 4'b0100);
    end
    cyc();
    check("ps_term_st", st(), 4'b0011);
    done_ack = 1'b1;
    cyc();
    done_ack = 1'b0;
    start(2, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("ps_rst_cnt", cnt, 0);
    check("ps_rst_st", st(), 4'b1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
